// File: rtl/piso16_pkg.sv
// Shared definitions for the 16-bit parallel-in/serial-out serializer.
package piso16_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/piso16_serializer_bit_counter.sv
// Saturating up-counter: async active-low reset, sync clear, enable, terminal-count flag.
module bit_counter #(
    parameter int MAX = 15,
    parameter int CW  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          tc
);

    assign tc = (count == CW'(MAX));

    // Holds at MAX instead of wrapping so a stray enable cannot restart the word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/piso16_serializer.sv
// Parallel-in/serial-out serializer with a load_valid/load_ready word handshake
// and registered sout/sout_valid/last outputs.
module piso16_serializer
    import piso16_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             fsm_state
);

    localparam int CW = $clog2(WIDTH);

    // Handshake: a word transfers on a rising edge where load_valid and load_ready are both 1;
    // load_ready is 1 in IDLE and during the final bit of a word, so words can run back-to-back.

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic             sout_next, valid_next, last_next;
    logic [CW-1:0]    cnt;
    logic             cnt_tc;
    logic             accept;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign load_ready = (state == IDLE) || cnt_tc;
    assign accept     = load_valid && load_ready;
    assign fsm_state  = state;

    bit_counter #(
        .MAX (WIDTH - 1),
        .CW  (CW)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .en    (state == SHIFT),
        .count (cnt),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_next = state;
        shreg_next = shreg;
        sout_next  = sout;
        valid_next = sout_valid;
        last_next  = last;
        if (accept) begin
            // First bit goes straight to sout; the register keeps the remaining bits.
            state_next = SHIFT;
            sout_next  = first_bit(d);
            shreg_next = shift_word(d);
            valid_next = 1'b1;
            last_next  = 1'b0;
        end else if (state == SHIFT) begin
            if (cnt_tc) begin
                state_next = IDLE;
                shreg_next = '0;
                sout_next  = 1'b0;
                valid_next = 1'b0;
                last_next  = 1'b0;
            end else begin
                sout_next  = first_bit(shreg);
                shreg_next = shift_word(shreg);
                last_next  = (cnt == CW'(WIDTH - 2));
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shreg      <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            last       <= 1'b0;
        end else begin
            state      <= state_next;
            shreg      <= shreg_next;
            sout       <= sout_next;
            sout_valid <= valid_next;
            last       <= last_next;
        end
    end

endmodule

// File: tb/tb_piso16_serializer.sv
// Directed bench for piso16_serializer: default, LSB-first and 4-bit configurations.
module tb_piso16_serializer;

    logic        clk;
    logic        a_rst, bc_rst;
    logic [15:0] a_d, b_d;
    logic [3:0]  c_d;
    logic        a_lv, b_lv, c_lv;
    logic        a_ready, a_sout, a_valid, a_last, a_state;
    logic        b_ready, b_sout, b_valid, b_last, b_state;
    logic        c_ready, c_sout, c_valid, c_last, c_state;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp16;
    logic [31:0] exp32;
    logic [7:0]  exp8;

    piso16_serializer #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .reset(a_rst), .d(a_d), .load_valid(a_lv), .load_ready(a_ready),
        .sout(a_sout), .sout_valid(a_valid), .last(a_last), .fsm_state(a_state)
    );

    piso16_serializer #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset(bc_rst), .d(b_d), .load_valid(b_lv), .load_ready(b_ready),
        .sout(b_sout), .sout_valid(b_valid), .last(b_last), .fsm_state(b_state)
    );

    piso16_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_c (
        .clk(clk), .reset(bc_rst), .d(c_d), .load_valid(c_lv), .load_ready(c_ready),
        .sout(c_sout), .sout_valid(c_valid), .last(c_last), .fsm_state(c_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input int sel, input string tag, input logic e_sout,
                              input logic e_valid, input logic e_last, input logic e_ready);
        logic [3:0] obs, exp;
        case (sel)
            0:       obs = {a_sout, a_valid, a_last, a_ready};
            1:       obs = {b_sout, b_valid, b_last, b_ready};
            default: obs = {c_sout, c_valid, c_last, c_ready};
        endcase
        exp = {e_sout, e_valid, e_last, e_ready};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed(sout,valid,last,ready)=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed_state=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        a_rst = 1'b0; bc_rst = 1'b0;
        a_d = '0; b_d = '0; c_d = '0;
        a_lv = 1'b0; b_lv = 1'b0; c_lv = 1'b0;

        // Reset values before any clock edge
        #2;
        expect_out(0, "rst_a", 1'b0, 1'b0, 1'b0, 1'b1);
        expect_out(1, "rst_b", 1'b0, 1'b0, 1'b0, 1'b1);
        expect_out(2, "rst_c", 1'b0, 1'b0, 1'b0, 1'b1);
        expect_state("rst_state_a", a_state, 1'b0);

        // Release reset and offer a word for the very next edge
        #5;
        a_rst = 1'b1; bc_rst = 1'b1;
        a_d = 16'h00F0; a_lv = 1'b1;
        tick();
        a_lv = 1'b0; a_d = 16'h0000;
        expect_state("shift_state_a", a_state, 1'b1);
        exp16 = 16'b0000000011110000;
        for (int i = 0; i < 16; i++) begin
            expect_out(0, $sformatf("w00f0_bit%0d", i), exp16[15-i], 1'b1, i == 15, i == 15);
            tick();
        end
        expect_out(0, "w00f0_idle", 1'b0, 1'b0, 1'b0, 1'b1);
        expect_state("idle_state_a", a_state, 1'b0);

        // Back-to-back A5A5 then 5A5A with load_valid held high
        a_d = 16'hA5A5; a_lv = 1'b1;
        tick();
        a_d = 16'h5A5A;
        exp32 = 32'hA5A55A5A;
        for (int i = 0; i < 32; i++) begin
            expect_out(0, $sformatf("b2b_bit%0d", i), exp32[31-i], 1'b1, (i % 16) == 15, (i % 16) == 15);
            if (i == 16) a_lv = 1'b0;
            tick();
        end
        expect_out(0, "b2b_idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // d and load_valid change mid-word while load_ready is low
        a_d = 16'h0000; a_lv = 1'b1;
        tick();
        a_lv = 1'b0;
        for (int i = 0; i < 16; i++) begin
            expect_out(0, $sformatf("hold_bit%0d", i), 1'b0, 1'b1, i == 15, i == 15);
            if (i == 5) begin
                a_d = 16'hFFFF; a_lv = 1'b1;
            end
            if (i == 14) a_lv = 1'b0;
            tick();
        end
        expect_out(0, "hold_idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset during bit 7 of FFFF
        a_d = 16'hFFFF; a_lv = 1'b1;
        tick();
        a_lv = 1'b0;
        for (int i = 0; i < 7; i++) begin
            expect_out(0, $sformatf("ffff_bit%0d", i), 1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        expect_out(0, "ffff_bit7", 1'b1, 1'b1, 1'b0, 1'b0);
        #3;
        a_rst = 1'b0;
        #1;
        expect_out(0, "midrst_async", 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        a_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out(0, $sformatf("midrst_idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // LSB-first: 0001 gives a 1 then fifteen 0s
        b_d = 16'h0001; b_lv = 1'b1;
        tick();
        b_lv = 1'b0;
        for (int i = 0; i < 16; i++) begin
            expect_out(1, $sformatf("lsb_bit%0d", i), i == 0, 1'b1, i == 15, i == 15);
            tick();
        end
        expect_out(1, "lsb_idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // 4-bit words 1011 back-to-back
        c_d = 4'b1011; c_lv = 1'b1;
        tick();
        exp8 = 8'b10111011;
        for (int i = 0; i < 8; i++) begin
            expect_out(2, $sformatf("w4_bit%0d", i), exp8[7-i], 1'b1, (i % 4) == 3, (i % 4) == 3);
            if (i == 4) c_lv = 1'b0;
            tick();
        end
        expect_out(2, "w4_idle", 1'b0, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
